// File: rtl/demux3bit_pkg.sv
// -----------------------------------------------------------------------------
// demux3bit_pkg
// Shared constants for the 3-bit stream demultiplexer:
//   WIDTH_DEF / DEPTH_DEF : default token width and per-channel FIFO depth
//   CH_A / CH_B           : in_sel encoding of the two destination channels
//   ptr_w()               : pointer width helper, $clog2(depth)
// -----------------------------------------------------------------------------
package demux3bit_pkg;

    localparam int WIDTH_DEF = 3;
    localparam int DEPTH_DEF = 2;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/demux3bit_fifo.sv
// -----------------------------------------------------------------------------
// demux3bit_fifo
// Small synchronous FIFO used once per output channel of the demultiplexer.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset; clears count, pointers, storage
//   push      : write push_data this cycle (ignored while full)
//   push_data : token to write
//   pop       : discard the head entry this cycle (ignored while empty)
//   full      : count == DEPTH
//   empty     : count == 0
//   head      : storage at the read pointer (valid when !empty)
// DEPTH must be a power of two, at least 2, so pointers wrap naturally.
// -----------------------------------------------------------------------------
module demux3bit_fifo
    import demux3bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic push_ok;
    logic pop_ok;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Guard here as well so a misbehaving caller cannot corrupt the count.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // Simultaneous push and pop leaves the count unchanged.
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux3bit_stream.sv
// -----------------------------------------------------------------------------
// demux3bit_stream
// Steers one 3-bit valid/ready input stream to channel A (in_sel=0) or
// channel B (in_sel=1). Each channel is buffered by its own FIFO so a stalled
// consumer on one side does not block or lose tokens for the other side.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : producer handshake; in_ready depends only on in_sel
//                        and the registered FIFO fill levels
//   in_data, in_sel    : token payload and destination channel
//   a_valid/a_data     : channel A head, popped when a_ready is high
//   b_valid/b_data     : channel B head, popped when b_ready is high
// Optional (macro DEMUX3BIT_STATS_EN):
//   a_count_o, b_count_o : saturating 16-bit counts of tokens popped per channel
//   drop_o               : registered pulse one cycle after an input stall
//                          (in_valid=1 while in_ready=0)
// -----------------------------------------------------------------------------
module demux3bit_stream
    import demux3bit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready
`ifdef DEMUX3BIT_STATS_EN
    ,
    output logic [15:0]      a_count_o,
    output logic [15:0]      b_count_o,
    output logic             drop_o
`endif
);

    logic a_full;
    logic a_empty;
    logic b_full;
    logic b_empty;
    logic accept;
    logic a_push;
    logic b_push;
    logic a_pop;
    logic b_pop;

    // No path from a_ready/b_ready: a full channel refuses even if it is
    // being drained in the same cycle.
    assign in_ready = (in_sel == CH_A) ? !a_full : !b_full;
    assign accept   = in_valid && in_ready;
    assign a_push   = accept && (in_sel == CH_A);
    assign b_push   = accept && (in_sel == CH_B);

    assign a_valid  = !a_empty;
    assign b_valid  = !b_empty;
    assign a_pop    = a_valid && a_ready;
    assign b_pop    = b_valid && b_ready;

    demux3bit_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push),
        .push_data (in_data),
        .pop       (a_pop),
        .full      (a_full),
        .empty     (a_empty),
        .head      (a_data)
    );

    demux3bit_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_data (in_data),
        .pop       (b_pop),
        .full      (b_full),
        .empty     (b_empty),
        .head      (b_data)
    );

`ifdef DEMUX3BIT_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] a_cnt_p1;
    logic [15:0] b_cnt_p1;
    logic        drop_p1;

    // Stage p1: statistics registered one edge after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_cnt_p1 <= '0;
            b_cnt_p1 <= '0;
            drop_p1  <= 1'b0;
        end else begin
            if (a_pop) begin
                a_cnt_p1 <= sat_inc(a_cnt_p1);
            end
            if (b_pop) begin
                b_cnt_p1 <= sat_inc(b_cnt_p1);
            end
            drop_p1 <= in_valid && !in_ready;
        end
    end

    assign a_count_o = a_cnt_p1;
    assign b_count_o = b_cnt_p1;
    assign drop_o    = drop_p1;
`endif

endmodule

// File: tb/tb_demux3bit_stream.sv
// -----------------------------------------------------------------------------
// tb_demux3bit_stream
// Self-checking bench: a table of hand-computed vectors, directed multi-cycle
// sequences, and random traffic compared against a queue-based model.
// Define DEMUX3BIT_STATS_EN to also check the statistics outputs.
// -----------------------------------------------------------------------------
module tb_demux3bit_stream;

    localparam int WIDTH = 3;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_ready;
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
`ifdef DEMUX3BIT_STATS_EN
    logic [15:0]      a_count_o;
    logic [15:0]      b_count_o;
    logic             drop_o;
`endif

    always #5 clk = ~clk;

    demux3bit_stream #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_ready  (in_ready),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready)
`ifdef DEMUX3BIT_STATS_EN
        ,
        .a_count_o (a_count_o),
        .b_count_o (b_count_o),
        .drop_o    (drop_o)
`endif
    );

    int passed = 0;
    int total  = 0;

    // Reference model: one queue per channel holding accepted, unpopped tokens.
    logic [WIDTH-1:0] qa[$];
    logic [WIDTH-1:0] qb[$];
    // Tokens observed leaving each channel (handshake completed).
    logic [WIDTH-1:0] rec_a[$];
    logic [WIDTH-1:0] rec_b[$];
    logic             last_ir;
    int               pops_a = 0;
    int               pops_b = 0;
    logic             exp_drop = 1'b0;
    int               drop_seen = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs just after the falling edge, check
    // in_ready before the rising edge, update the model at the rising edge,
    // then check registered outputs at the next falling edge.
    task automatic cycle(input logic r, input logic v, input logic [WIDTH-1:0] d,
                         input logic s, input logic ar, input logic br);
        logic exp_ir;
        rst      = r;
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        a_ready  = ar;
        b_ready  = br;
        #1;
        exp_ir = s ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
        last_ir = in_ready;
        check("in_ready", 16'(in_ready), 16'(exp_ir));
        if (!r) begin
            if (a_valid && ar) rec_a.push_back(a_data);
            if (b_valid && br) rec_b.push_back(b_data);
        end
        @(posedge clk);
        if (r) begin
            qa.delete();
            qb.delete();
            pops_a   = 0;
            pops_b   = 0;
            exp_drop = 1'b0;
        end else begin
            if (ar && qa.size() > 0) begin
                void'(qa.pop_front());
                if (pops_a < 65535) pops_a++;
            end
            if (br && qb.size() > 0) begin
                void'(qb.pop_front());
                if (pops_b < 65535) pops_b++;
            end
            if (v && exp_ir) begin
                if (s) qb.push_back(d);
                else   qa.push_back(d);
            end
            exp_drop = v && !exp_ir;
        end
        @(negedge clk);
        check("a_valid", 16'(a_valid), 16'(qa.size() != 0));
        if (qa.size() != 0) check("a_data", 16'(a_data), 16'(qa[0]));
        check("b_valid", 16'(b_valid), 16'(qb.size() != 0));
        if (qb.size() != 0) check("b_data", 16'(b_data), 16'(qb[0]));
`ifdef DEMUX3BIT_STATS_EN
        check("a_count_o", a_count_o, 16'(pops_a));
        check("b_count_o", b_count_o, 16'(pops_b));
        check("drop_o", 16'(drop_o), 16'(exp_drop));
        if (drop_o) drop_seen++;
`endif
    endtask

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             s;
        logic             ar;
        logic             br;
        logic             ir;
        logic             av;
        logic [WIDTH-1:0] ad;
        logic             bv;
        logic [WIDTH-1:0] bd;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int idx;
        int cyc;
        int acc_cycles;
        logic pend_v;
        logic [WIDTH-1:0] pend_d;
        logic pend_s;

        // Reset release then single token to A; fill B, push A past full B,
        // then drain B in order. Stale a_data/b_data follow storage[rdptr].
        //            v   d       s   ar  br  ir  av  ad      bv  bd
        tbl[0] = '{1'b1, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b101, 1'b0, 3'b000};
        tbl[1] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b000};
        tbl[2] = '{1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001};
        tbl[3] = '{1'b1, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 3'b001};
        tbl[4] = '{1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 3'b001};
        tbl[5] = '{1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b1, 3'b001};
        tbl[6] = '{1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 3'b010};
        tbl[7] = '{1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 3'b001};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0;
        a_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 3'b110, 1'b1, 1'b1, 1'b1);
        check("rst_a_data", 16'(a_data), 16'h0);
        check("rst_b_data", 16'(b_data), 16'h0);
        check("rst_a_valid", 16'(a_valid), 16'h0);
        check("rst_b_valid", 16'(b_valid), 16'h0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].ar, tbl[i].br);
            check($sformatf("tbl%0d_ir", i), 16'(last_ir), 16'(tbl[i].ir));
            check($sformatf("tbl%0d_av", i), 16'(a_valid), 16'(tbl[i].av));
            check($sformatf("tbl%0d_ad", i), 16'(a_data),  16'(tbl[i].ad));
            check($sformatf("tbl%0d_bv", i), 16'(b_valid), 16'(tbl[i].bv));
            check($sformatf("tbl%0d_bd", i), 16'(b_data),  16'(tbl[i].bd));
        end

        // Full B drained while pushing: one stall, then 1 token per cycle.
        cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        rec_b.delete();
        cycle(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
        idx = 2;
        acc_cycles = 0;
        for (cyc = 0; cyc < 30 && rec_b.size() < 8; cyc++) begin
            if (idx < 8) acc_cycles++;
            cycle(1'b0, idx < 8, 3'(idx), 1'b1, 1'b0, 1'b1);
            if (idx < 8 && last_ir) idx++;
        end
        check("thru_cycles", 16'(acc_cycles), 16'd7);
        check("thru_count", 16'(rec_b.size()), 16'd8);
        for (int i = 0; i < rec_b.size(); i++) begin
            check($sformatf("thru_b%0d", i), 16'(rec_b[i]), 16'(i));
        end

        // Pointer wrap on A with a_ready toggling.
        cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        rec_a.delete();
        idx = 0;
        for (cyc = 0; cyc < 40 && rec_a.size() < 6; cyc++) begin
            cycle(1'b0, idx < 6, 3'(idx), 1'b0, (cyc % 2) == 0, 1'b0);
            if (idx < 6 && last_ir) idx++;
        end
        check("wrap_count", 16'(rec_a.size()), 16'd6);
        for (int i = 0; i < rec_a.size(); i++) begin
            check($sformatf("wrap_a%0d", i), 16'(rec_a[i]), 16'(i));
        end

        // Reset with A=2 tokens and B=1 token buffered.
        cycle(1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        check("midrst_av", 16'(a_valid), 16'h0);
        check("midrst_bv", 16'(b_valid), 16'h0);
        check("midrst_ad", 16'(a_data), 16'h0);
        check("midrst_bd", 16'(b_data), 16'h0);
        cycle(1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0);
        check("postrst_av", 16'(a_valid), 16'h0);
        check("postrst_bv", 16'(b_valid), 16'h1);
        check("postrst_bd", 16'(b_data), 16'h3);

`ifdef DEMUX3BIT_STATS_EN
        // 5 pops on A and 2 stall cycles on B.
        cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        drop_seen = 0;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'(i), 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        check("stats_a", a_count_o, 16'd5);
        check("stats_b", b_count_o, 16'd0);
        check("stats_drops", 16'(drop_seen), 16'd2);
`endif

        // Random traffic; a stalled token is held until accepted.
        cycle(1'b1, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
        pend_v = 1'b0; pend_d = '0; pend_s = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend_v) begin
                pend_v = ($urandom_range(0, 3) != 0);
                pend_d = 3'($urandom_range(0, 7));
                pend_s = 1'($urandom_range(0, 1));
            end
            cycle(($urandom_range(0, 99) == 0), pend_v, pend_d, pend_s,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (pend_v && (last_ir || rst)) pend_v = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
